pixel_assembler: RTL and testbench
==================================

// Module: pixel_assembler
// PURPOSE
//   Parametrised successor to the fixed 3-register pixel bank. Assembles CHANNELS
//   consecutive UART bytes into one pixel word, with a channel counter instead of
//   per-channel load strobes. Output uses a valid/ready handshake, backed by a
//   one-deep output register. A timeout discards a partial pixel and resyncs the
//   byte stream. Sits between the UART receiver and the pixel/frame consumer.
// PARAMETERS
//   CHANNELS        3    bytes per pixel (>=1); pixel width = 8*CHANNELS
//   MSB_FIRST       1    1: first byte -> pixel[8*CHANNELS-1 -: 8] ({R,G,B}); 0: first byte -> pixel[7:0]
//   TIMEOUT_CYCLES  0    idle cycles tolerated mid-pixel before discard; 0 disables timeout
// PORTS
//   clk          in   1           system clock, all logic on rising edge
//   reset        in   1           asynchronous reset, active-low
//   rx_data_out  in   8           received byte, valid only when rx_ready=1
//   rx_ready     in   1           one-cycle strobe: rx_data_out holds a new byte
//   clear        in   1           synchronous flush, active-high
//   pixel_ready  in   1           consumer accepts pixel this cycle
//   pixel        out  8*CHANNELS  assembled pixel, stable while pixel_valid && !pixel_ready
//   pixel_valid  out  1           pixel holds an unconsumed word
//   busy         out  1           partial pixel in progress (ch_idx != 0)
//   overflow     out  1           sticky: a byte was dropped in STALL; cleared by reset/clear
//   err_timeout  out  1           one-cycle pulse: partial pixel discarded on timeout
// BEHAVIOUR
//   Reset (reset=0, async): pixel=0, pixel_valid=0, busy=0, overflow=0, err_timeout=0,
//     ch_idx=0, idle counter=0, assembly register=0, state=COLLECT.
//   clear=1 (sync): same end state as reset, applied at the next edge. Takes priority
//     over rx_ready and pixel_ready in that cycle.
//   Handshake: a transfer occurs on a cycle with pixel_valid && pixel_ready.
//     pixel_valid falls the cycle after the transfer unless a new pixel loads on the same edge.
//   State COLLECT, rx_ready=1: byte written to slot ch_idx of the assembly register.
//     - ch_idx < CHANNELS-1: ch_idx++.
//     - ch_idx == CHANNELS-1: ch_idx=0 and the pixel is complete.
//       If the output is free (!pixel_valid, or a transfer occurs this cycle), the
//       assembly register loads into pixel with pixel_valid=1 at t+1 (latency 1 from
//       the last byte's strobe). Otherwise go to STALL.
//   State STALL: the complete pixel waits in the assembly register.
//     - rx_ready=1 drops the byte and sets overflow=1.
//     - On the first cycle with a transfer: pixel <= assembly, pixel_valid stays 1, go to COLLECT.
//     - A byte arriving in that same exit cycle is also dropped.
//   Slot mapping: slot k = pixel[8*(CHANNELS-1-k) +: 8] if MSB_FIRST, else pixel[8*k +: 8].
//   Timeout (TIMEOUT_CYCLES>0, COLLECT, busy=1):
//     - Idle counter increments each cycle without rx_ready and resets on rx_ready.
//     - When it reaches TIMEOUT_CYCLES: ch_idx=0, counter=0, err_timeout=1 for one cycle.
//     - Partial bytes are discarded; pixel and pixel_valid are unaffected.
//     - Counter is held at 0 when busy=0 or in STALL.
//   CHANNELS==1: every accepted byte completes a pixel; busy is constantly 0; timeout never fires.
//   Bytes are never reordered, and pixel never changes while pixel_valid && !pixel_ready.
//   Counter widths: ch_idx $clog2(CHANNELS) (min 1); idle counter $clog2(TIMEOUT_CYCLES+1).
// TESTING
//   1 Reset, send 0x11,0x22,0x33 with pixel_ready=1 -> pixel=24'h112233, pixel_valid=1
//     one cycle after the 3rd strobe, then 0 after the transfer.
//   2 MSB_FIRST=0, same bytes -> pixel=24'h332211.
//   3 pixel_ready=0, send 2 full pixels (AA BB CC, DD EE FF) then 1 more byte ->
//     pixel holds AABBCC, state STALL, overflow=1;
//     pulse pixel_ready -> pixel=DDEEFF next cycle, pixel_valid stays 1.
//   4 TIMEOUT_CYCLES=10: send 0x01, idle 10 cycles -> err_timeout pulse, busy=0;
//     then 0x44,0x55,0x66 -> pixel=24'h445566.
//   5 Completion and transfer on the same edge -> new pixel loads, pixel_valid remains 1,
//     no overflow.
//   6 Assert reset (async) mid-pixel and in STALL; also assert clear together with rx_ready
//     -> all outputs return to reset values and the byte is ignored.

Source files
------------

// File: rtl/pixel_assembler.sv
// Collects CHANNELS consecutive UART bytes into one pixel word and presents it
// on a valid/ready output backed by a single holding register.
module pixel_assembler #(
  parameter int CHANNELS       = 3,
  parameter bit MSB_FIRST      = 1'b1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data_out,
  input  logic                  rx_ready,
  input  logic                  clear,
  input  logic                  pixel_ready,
  output logic [8*CHANNELS-1:0] pixel,
  output logic                  pixel_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic                  err_timeout
);

  localparam int PW    = 8 * CHANNELS;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] CH_LAST  = IDX_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {COLLECT, STALL} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  ch_idx_reg;
  logic [CNT_W-1:0]  idle_reg;
  logic [PW-1:0]     asm_reg;
  logic [PW-1:0]     asm_next;
  logic [PW-1:0]     pixel_reg;
  logic              valid_reg;
  logic              overflow_reg;
  logic              err_reg;
  logic              transfer;

  assign transfer = valid_reg && pixel_ready;

  // Assembly register with the incoming byte merged into the active slot.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slot
    localparam int POS = MSB_FIRST ? 8 * (CHANNELS - 1 - gi) : 8 * gi;
    assign asm_next[POS +: 8] = (rx_ready && (ch_idx_reg == IDX_W'(gi))) ? rx_data_out
                                                                          : asm_reg[POS +: 8];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= COLLECT;
      ch_idx_reg   <= '0;
      idle_reg     <= '0;
      asm_reg      <= '0;
      pixel_reg    <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else if (clear) begin
      state_reg    <= COLLECT;
      ch_idx_reg   <= '0;
      idle_reg     <= '0;
      asm_reg      <= '0;
      pixel_reg    <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      if (transfer) valid_reg <= 1'b0;
      case (state_reg)
        COLLECT: begin
          if (rx_ready) begin
            asm_reg  <= asm_next;
            idle_reg <= '0;
            if (ch_idx_reg == CH_LAST) begin
              ch_idx_reg <= '0;
              if (!valid_reg || transfer) begin
                pixel_reg <= asm_next;
                valid_reg <= 1'b1;
              end else begin
                state_reg <= STALL;
              end
            end else begin
              ch_idx_reg <= ch_idx_reg + 1'b1;
            end
          end else if ((TIMEOUT_CYCLES > 0) && (ch_idx_reg != '0)) begin
            if (idle_reg == CNT_LAST) begin
              ch_idx_reg <= '0;
              idle_reg   <= '0;
              err_reg    <= 1'b1;
            end else begin
              idle_reg <= idle_reg + 1'b1;
            end
          end else begin
            idle_reg <= '0;
          end
        end
        STALL: begin
          // Any byte arriving while a finished pixel waits is lost, even on the exit cycle.
          idle_reg <= '0;
          if (rx_ready) overflow_reg <= 1'b1;
          if (transfer) begin
            pixel_reg <= asm_reg;
            valid_reg <= 1'b1;
            state_reg <= COLLECT;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign pixel       = pixel_reg;
  assign pixel_valid = valid_reg;
  assign busy        = (ch_idx_reg != '0);
  assign overflow    = overflow_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_pixel_assembler.sv
// Scoreboard bench: three pixel_assembler variants (default, LSB-first, timeout=10)
// share one clock and reset; a negedge monitor checks every pixel handed over.
module tb_pixel_assembler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] rx_data  [3];
  logic       rx_ready [3];
  logic       clear    [3];
  logic       pr       [3];
  wire [23:0] pix      [3];
  wire        pv       [3];
  wire        busy     [3];
  wire        ovf      [3];
  wire        err      [3];

  int checks = 0;
  int errors = 0;
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] q2[$];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    pixel_assembler #(
      .CHANNELS      (3),
      .MSB_FIRST     ((gi == 1) ? 1'b0 : 1'b1),
      .TIMEOUT_CYCLES((gi == 2) ? 10 : 0)
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n),
      .rx_data_out(rx_data[gi]),
      .rx_ready   (rx_ready[gi]),
      .clear      (clear[gi]),
      .pixel_ready(pr[gi]),
      .pixel      (pix[gi]),
      .pixel_valid(pv[gi]),
      .busy       (busy[gi]),
      .overflow   (ovf[gi]),
      .err_timeout(err[gi])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic [23:0] act);
    logic [23:0] e;
    int sz;
    case (i)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL mon%0d_unexpected: got %h expected no pixel", i, act);
    end else begin
      case (i)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      $display("txn inst%0d pixel %h expected %h", i, act, e);
      chk($sformatf("mon%0d_pixel", i), 32'(act), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (pv[0] && pr[0]) mon(0, pix[0]);
      if (pv[1] && pr[1]) mon(1, pix[1]);
      if (pv[2] && pr[2]) mon(2, pix[2]);
    end
  end

  task automatic strobe(input int i, input logic [7:0] b);
    rx_data[i]  = b;
    rx_ready[i] = 1'b1;
    @(posedge clk); #1;
    rx_ready[i] = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data[i] = 8'h00; rx_ready[i] = 1'b0; clear[i] = 1'b0; pr[i] = 1'b0;
    end
    tick(2);
    chk("rst_pixel", 32'(pix[0]), 32'h0);
    chk("rst_valid", 32'(pv[0]), 32'h0);
    chk("rst_busy", 32'(busy[0]), 32'h0);
    chk("rst_ovf", 32'(ovf[0]), 32'h0);
    chk("rst_err", 32'(err[0]), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // 1: basic MSB-first assembly, latency and valid drop after transfer
    pr[0] = 1'b1;
    q0.push_back(24'h112233);
    strobe(0, 8'h11); strobe(0, 8'h22);
    chk("t1_valid_before", 32'(pv[0]), 32'h0);
    chk("t1_busy", 32'(busy[0]), 32'h1);
    strobe(0, 8'h33);
    chk("t1_valid", 32'(pv[0]), 32'h1);
    chk("t1_pixel", 32'(pix[0]), 32'h112233);
    tick(1);
    chk("t1_valid_after", 32'(pv[0]), 32'h0);

    // 2: LSB-first slot mapping
    pr[1] = 1'b1;
    q1.push_back(24'h332211);
    strobe(1, 8'h11); strobe(1, 8'h22); strobe(1, 8'h33);
    chk("t2_pixel", 32'(pix[1]), 32'h332211);
    tick(2);

    // 3: backpressure, STALL and overflow
    pr[0] = 1'b0;
    q0.push_back(24'hAABBCC);
    q0.push_back(24'hDDEEFF);
    strobe(0, 8'hAA); strobe(0, 8'hBB); strobe(0, 8'hCC);
    strobe(0, 8'hDD); strobe(0, 8'hEE); strobe(0, 8'hFF);
    chk("t3_valid", 32'(pv[0]), 32'h1);
    chk("t3_ovf_before", 32'(ovf[0]), 32'h0);
    strobe(0, 8'h77);
    chk("t3_ovf", 32'(ovf[0]), 32'h1);
    chk("t3_hold", 32'(pix[0]), 32'hAABBCC);
    chk("t3_busy", 32'(busy[0]), 32'h0);
    pr[0] = 1'b1;
    tick(1);
    pr[0] = 1'b0;
    chk("t3_next_pixel", 32'(pix[0]), 32'hDDEEFF);
    chk("t3_next_valid", 32'(pv[0]), 32'h1);
    pr[0] = 1'b1;
    tick(2);
    pr[0] = 1'b0;
    chk("t3_drained", 32'(pv[0]), 32'h0);
    chk("t3_ovf_sticky", 32'(ovf[0]), 32'h1);
    clear[0] = 1'b1;
    tick(1);
    clear[0] = 1'b0;
    chk("t3_ovf_cleared", 32'(ovf[0]), 32'h0);

    // 4: timeout discards a partial pixel
    pr[2] = 1'b1;
    strobe(2, 8'h01);
    chk("t4_busy", 32'(busy[2]), 32'h1);
    tick(9);
    chk("t4_err_early", 32'(err[2]), 32'h0);
    chk("t4_busy_early", 32'(busy[2]), 32'h1);
    tick(1);
    chk("t4_err", 32'(err[2]), 32'h1);
    chk("t4_busy_after", 32'(busy[2]), 32'h0);
    chk("t4_valid", 32'(pv[2]), 32'h0);
    tick(1);
    chk("t4_err_pulse", 32'(err[2]), 32'h0);
    q2.push_back(24'h445566);
    strobe(2, 8'h44); strobe(2, 8'h55); strobe(2, 8'h66);
    chk("t4_pixel", 32'(pix[2]), 32'h445566);
    tick(2);

    // 5: completion and transfer on the same edge
    pr[0] = 1'b0;
    q0.push_back(24'h010203);
    q0.push_back(24'h040506);
    strobe(0, 8'h01); strobe(0, 8'h02); strobe(0, 8'h03);
    strobe(0, 8'h04); strobe(0, 8'h05);
    pr[0] = 1'b1;
    strobe(0, 8'h06);
    chk("t5_valid", 32'(pv[0]), 32'h1);
    chk("t5_pixel", 32'(pix[0]), 32'h040506);
    chk("t5_ovf", 32'(ovf[0]), 32'h0);
    tick(1);
    chk("t5_drained", 32'(pv[0]), 32'h0);

    // 6: async reset mid-pixel, async reset in STALL, clear beating rx_ready
    strobe(0, 8'h12);
    chk("t6_busy", 32'(busy[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy[0]), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pr[0] = 1'b0;
    strobe(0, 8'hA1); strobe(0, 8'hA2); strobe(0, 8'hA3);
    strobe(0, 8'hB1); strobe(0, 8'hB2); strobe(0, 8'hB3);
    strobe(0, 8'hC1);
    chk("t6_stall_ovf", 32'(ovf[0]), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(pv[0]), 32'h0);
    chk("t6_rst_ovf", 32'(ovf[0]), 32'h0);
    chk("t6_rst_pixel", 32'(pix[0]), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pr[0] = 1'b1;
    strobe(0, 8'h31);
    rx_data[0] = 8'h99; rx_ready[0] = 1'b1; clear[0] = 1'b1;
    tick(1);
    rx_ready[0] = 1'b0; clear[0] = 1'b0;
    chk("t6_clear_busy", 32'(busy[0]), 32'h0);
    chk("t6_clear_valid", 32'(pv[0]), 32'h0);
    q0.push_back(24'hABCDEF);
    strobe(0, 8'hAB); strobe(0, 8'hCD); strobe(0, 8'hEF);
    tick(2);

    chk("q0_empty", 32'(q0.size()), 32'h0);
    chk("q1_empty", 32'(q1.size()), 32'h0);
    chk("q2_empty", 32'(q2.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
